// File: rtl/alu_exec_ctrl_if.sv
// Decode-to-execute instruction handshake.
//   op_valid  decode presents an instruction
//   op_ready  execute controller can accept (IDLE only)
//   op_code   20-bit ALU instruction code
//   op_ra     operand A register index, also the destination
//   op_rb     operand B register index
// master: decode side. slave: execute controller.
interface alu_exec_ctrl_if #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned OP_W   = 20
);
  logic              op_valid;
  logic              op_ready;
  logic [OP_W-1:0]   op_code;
  logic [REG_AW-1:0] op_ra;
  logic [REG_AW-1:0] op_rb;

  modport master (output op_valid, op_code, op_ra, op_rb, input op_ready);
  modport slave  (input op_valid, op_code, op_ra, op_rb, output op_ready);
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for the 20-bit ALU: accepts one instruction,
// reads both operands, drives the ALU, writes back and keeps Z/N/C.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op_if (slave)       decode handshake (valid/ready, code, ra, rb)
//   rf_rd_*             register-file read ports (1-cycle read latency)
//   rf_we/wr_addr/data  register-file write port
//   alu_*               ALU control, operands, carry in/out, result
//   flag_z/n/c          status flags
//   busy                high outside IDLE
//   illegal             one-cycle pulse after accepting an unknown code
module alu_exec_ctrl #(
  parameter  int unsigned DATA_W = 20,
  parameter  int unsigned REG_AW = 4,
  localparam int unsigned OP_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  alu_exec_ctrl_if.slave    op_if,
  output logic [REG_AW-1:0] rf_rd_a_addr,
  output logic [REG_AW-1:0] rf_rd_b_addr,
  input  logic [DATA_W-1:0] rf_rd_a_data,
  input  logic [DATA_W-1:0] rf_rd_b_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [OP_W-1:0]   alu_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              busy,
  output logic              illegal
);

  localparam logic [OP_W-1:0] OP_NOT   = 20'h000A1;
  localparam logic [OP_W-1:0] OP_OR    = 20'h000C9;
  localparam logic [OP_W-1:0] OP_AND   = 20'h000B5;
  localparam logic [OP_W-1:0] OP_XOR   = 20'h000DD;
  localparam logic [OP_W-1:0] OP_SHFTR = 20'h000F1;
  localparam logic [OP_W-1:0] OP_SHFTL = 20'h00105;
  localparam logic [OP_W-1:0] OP_ROTR  = 20'h00119;
  localparam logic [OP_W-1:0] OP_ROTL  = 20'h0012D;
  localparam logic [OP_W-1:0] OP_SWAP  = 20'h00011;
  localparam logic [OP_W-1:0] OP_INC   = 20'h00141;
  localparam logic [OP_W-1:0] OP_DEC   = 20'h00155;
  localparam logic [OP_W-1:0] OP_ADD   = 20'h00169;
  localparam logic [OP_W-1:0] OP_ADDC  = 20'h0017D;
  localparam logic [OP_W-1:0] OP_SUB   = 20'h00191;
  localparam logic [OP_W-1:0] OP_SUBC  = 20'h001A5;
  localparam logic [OP_W-1:0] OP_EQ    = 20'h001B9;
  localparam logic [OP_W-1:0] OP_GT    = 20'h001CD;
  localparam logic [OP_W-1:0] OP_LT    = 20'h001E1;
  localparam logic [OP_W-1:0] OP_GET   = 20'h001F5;
  localparam logic [OP_W-1:0] OP_LET   = 20'h00209;

  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_EXEC, ST_WB, ST_WB2
  } state_e;

  typedef enum logic [2:0] {
    CLS_WRITE, CLS_SWAP, CLS_CMP, CLS_ILL
  } op_cls_e;

  // Logic, shift/rotate and arithmetic share one writeback/flag rule.
  function automatic op_cls_e op_class(input logic [OP_W-1:0] code);
    case (code)
      OP_NOT, OP_OR, OP_AND, OP_XOR,
      OP_SHFTR, OP_SHFTL, OP_ROTR, OP_ROTL,
      OP_INC, OP_DEC, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: op_class = CLS_WRITE;
      OP_SWAP:                                          op_class = CLS_SWAP;
      OP_EQ, OP_GT, OP_LT, OP_GET, OP_LET:              op_class = CLS_CMP;
      default:                                          op_class = CLS_ILL;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_AW-1:0] ra_q, ra_d;
  logic [REG_AW-1:0] rb_q, rb_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   alu_instr_q, alu_instr_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_c_q, flag_c_d;
  logic              op_ready_q, op_ready_d;
  logic              busy_q, busy_d;
  logic              illegal_q, illegal_d;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    a_d          = a_q;
    b_d          = b_q;
    alu_instr_d  = alu_instr_q;
    rf_we_d      = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    flag_z_d     = flag_z_q;
    flag_n_d     = flag_n_q;
    flag_c_d     = flag_c_q;
    illegal_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_if.op_valid && op_ready_q) begin
          op_d = op_if.op_code;
          ra_d = op_if.op_ra;
          rb_d = op_if.op_rb;
          if (op_class(op_if.op_code) == CLS_ILL) illegal_d = 1'b1;
          else                                     state_d   = ST_READ;
        end
      end
      ST_READ: begin
        a_d         = rf_rd_a_data;
        b_d         = rf_rd_b_data;
        alu_instr_d = op_q;
        state_d     = ST_EXEC;
      end
      // ALU result/carry are captured straight into the write port and
      // flags so they are visible during WB.
      ST_EXEC: begin
        state_d = ST_WB;
        case (op_class(op_q))
          CLS_WRITE: begin
            rf_we_d      = 1'b1;
            rf_wr_addr_d = ra_q;
            rf_wr_data_d = alu_result;
            flag_z_d     = (alu_result == '0);
            flag_n_d     = alu_result[DATA_W-1];
            if (op_q == OP_ADDC || op_q == OP_SUBC) flag_c_d = alu_carry_out;
          end
          CLS_SWAP: begin
            rf_we_d      = 1'b1;
            rf_wr_addr_d = ra_q;
            rf_wr_data_d = b_q;
          end
          CLS_CMP: begin
            case (op_q)
              OP_EQ:  flag_z_d = (a_q == b_q);
              OP_GT:  flag_n_d = (a_q > b_q);
              OP_LT:  flag_n_d = (a_q < b_q);
              OP_GET: begin
                flag_z_d = (a_q >= b_q);
                flag_n_d = !(a_q >= b_q);
              end
              OP_LET: begin
                flag_z_d = (a_q <= b_q);
                flag_n_d = (a_q <= b_q);
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      // SWAP second half: A goes to rb; with ra==rb this restores the value.
      ST_WB: begin
        if (op_q == OP_SWAP) begin
          rf_we_d      = 1'b1;
          rf_wr_addr_d = rb_q;
          rf_wr_data_d = a_q;
          state_d      = ST_WB2;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WB2:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    op_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_instr_q  <= '0;
      rf_we_q      <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      flag_z_q     <= 1'b0;
      flag_n_q     <= 1'b0;
      flag_c_q     <= 1'b0;
      op_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      a_q          <= a_d;
      b_q          <= b_d;
      alu_instr_q  <= alu_instr_d;
      rf_we_q      <= rf_we_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      flag_z_q     <= flag_z_d;
      flag_n_q     <= flag_n_d;
      flag_c_q     <= flag_c_d;
      op_ready_q   <= op_ready_d;
      busy_q       <= busy_d;
      illegal_q    <= illegal_d;
    end
  end

  // Read addresses come from the handshake while IDLE so the register
  // file's one-cycle read lands in READ.
  assign rf_rd_a_addr = (state_q == ST_IDLE) ? op_if.op_ra : ra_q;
  assign rf_rd_b_addr = (state_q == ST_IDLE) ? op_if.op_rb : rb_q;

  assign op_if.op_ready = op_ready_q;
  assign busy           = busy_q;
  assign illegal        = illegal_q;
  assign rf_we          = rf_we_q;
  assign rf_wr_addr     = rf_wr_addr_q;
  assign rf_wr_data     = rf_wr_data_q;
  assign alu_instr      = alu_instr_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_carry_in   = flag_c_q;
  assign flag_z         = flag_z_q;
  assign flag_n         = flag_n_q;
  assign flag_c         = flag_c_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a register-file and ALU model.
module tb_alu_exec_ctrl;

  localparam logic [19:0] C_XOR  = 20'h000DD;
  localparam logic [19:0] C_SWAP = 20'h00011;
  localparam logic [19:0] C_ADD  = 20'h00169;
  localparam logic [19:0] C_ADDC = 20'h0017D;
  localparam logic [19:0] C_SUB  = 20'h00191;
  localparam logic [19:0] C_LT   = 20'h001E1;
  localparam logic [19:0] C_GET  = 20'h001F5;

  logic        clk;
  logic        rst;
  logic [3:0]  rf_rd_a_addr, rf_rd_b_addr;
  logic [19:0] rf_rd_a_data, rf_rd_b_data;
  logic        rf_we;
  logic [3:0]  rf_wr_addr;
  logic [19:0] rf_wr_data;
  logic [19:0] alu_instr, alu_a, alu_b, alu_result;
  logic        alu_carry_in, alu_carry_out;
  logic        flag_z, flag_n, flag_c, busy, illegal;

  logic        ld_we;
  logic [3:0]  ld_addr;
  logic [19:0] ld_data;
  logic [19:0] rf [16];

  int n_total = 0;
  int n_bad   = 0;

  alu_exec_ctrl_if #(.REG_AW(4)) op_if ();

  alu_exec_ctrl #(.DATA_W(20), .REG_AW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .op_if         (op_if),
    .rf_rd_a_addr  (rf_rd_a_addr),
    .rf_rd_b_addr  (rf_rd_b_addr),
    .rf_rd_a_data  (rf_rd_a_data),
    .rf_rd_b_data  (rf_rd_b_data),
    .rf_we         (rf_we),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data),
    .alu_instr     (alu_instr),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_carry_in  (alu_carry_in),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .flag_z        (flag_z),
    .flag_n        (flag_n),
    .flag_c        (flag_c),
    .busy          (busy),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (rf_we) rf[rf_wr_addr] <= rf_wr_data;
    if (ld_we) rf[ld_addr] <= ld_data;
    rf_rd_a_data <= rf[rf_rd_a_addr];
    rf_rd_b_data <= rf[rf_rd_b_addr];
  end

  // ALU subset used by the vectors.
  always_comb begin
    alu_result    = '0;
    alu_carry_out = 1'b0;
    case (alu_instr)
      C_ADD:  {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      C_ADDC: {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + 21'(alu_carry_in);
      C_SUB:  {alu_carry_out, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      C_XOR:  alu_result = alu_a ^ alu_b;
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rf_load(input logic [3:0] a, input logic [19:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // Present an op, wait for acceptance, leave the valid low afterwards.
  task automatic accept(input string tag, input logic [19:0] code,
                        input logic [3:0] ra, input logic [3:0] rb);
    int n;
    op_if.op_valid = 1'b1; op_if.op_code = code; op_if.op_ra = ra; op_if.op_rb = rb;
    n = 0;
    while (!op_if.op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq({tag, "_rdy_to"}, 32'(op_if.op_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    op_if.op_valid = 1'b0;
  endtask

  // Run one op to its WB cycle and check write port and flags there.
  task automatic do_op(input string tag, input logic [19:0] code,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic exp_we, input logic [3:0] exp_addr,
                       input logic [19:0] exp_data, input logic [2:0] exp_flg,
                       input logic exp_cin);
    accept(tag, code, ra, rb);
    check_eq({tag, "_rd_rdy"}, 32'(op_if.op_ready), 32'd0);
    check_eq({tag, "_rd_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_rd_we"}, 32'(rf_we), 32'd0);
    @(negedge clk);
    check_eq({tag, "_ex_instr"}, 32'(alu_instr), 32'(code));
    check_eq({tag, "_ex_cin"}, 32'(alu_carry_in), 32'(exp_cin));
    check_eq({tag, "_ex_we"}, 32'(rf_we), 32'd0);
    @(negedge clk);
    check_eq({tag, "_wb_we"}, 32'(rf_we), 32'(exp_we));
    if (exp_we) begin
      check_eq({tag, "_wb_addr"}, 32'(rf_wr_addr), 32'(exp_addr));
      check_eq({tag, "_wb_data"}, 32'(rf_wr_data), 32'(exp_data));
    end
    check_eq({tag, "_flags"}, 32'({flag_z, flag_n, flag_c}), 32'(exp_flg));
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    check_eq({tag, "_idle_rdy"}, 32'(op_if.op_ready), 32'd1);
    check_eq({tag, "_idle_we"}, 32'(rf_we), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    op_if.op_valid = 1'b0; op_if.op_code = '0; op_if.op_ra = '0; op_if.op_rb = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_rdy", 32'(op_if.op_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ill", 32'(illegal), 32'd0);
    check_eq("rst_we", 32'(rf_we), 32'd0);
    check_eq("rst_waddr", 32'(rf_wr_addr), 32'd0);
    check_eq("rst_wdata", 32'(rf_wr_data), 32'd0);
    check_eq("rst_instr", 32'(alu_instr), 32'd0);
    check_eq("rst_ab", 32'({alu_a, alu_b} == 40'd0), 32'd1);
    check_eq("rst_flags", 32'({flag_z, flag_n, flag_c}), 32'd0);
    rst = 1'b0;

    rf_load(4'd1, 20'h00005);  rf_load(4'd2, 20'h00003);
    rf_load(4'd3, 20'h12345);  rf_load(4'd4, 20'h0ABCD);
    rf_load(4'd5, 20'hFFFFF);  rf_load(4'd6, 20'h00001);
    rf_load(4'd7, 20'h80000);  rf_load(4'd8, 20'h00001);
    rf_load(4'd9, 20'h00007);  rf_load(4'd10, 20'h00007);
    rf_load(4'd11, 20'h00002); rf_load(4'd12, 20'h00009);
    rf_load(4'd13, 20'h00010); rf_load(4'd14, 20'h00020);

    // ADD 5+3 -> r1=8, flags clear
    do_op("add", C_ADD, 4'd1, 4'd2, 1'b1, 4'd1, 20'h00008, 3'b000, 1'b0);
    idle_chk("add");
    // XOR sets N from bit 19
    do_op("xor", C_XOR, 4'd7, 4'd8, 1'b1, 4'd7, 20'h80001, 3'b010, 1'b0);
    idle_chk("xor");
    // ADDC FFFFF+1+0 wraps -> 0 with carry
    do_op("addc0", C_ADDC, 4'd5, 4'd6, 1'b1, 4'd5, 20'h00000, 3'b101, 1'b0);
    idle_chk("addc0");
    // ADDC with C=1: FFFFF+0+1 -> 0, Z=1, C=1
    rf_load(4'd1, 20'hFFFFF);
    rf_load(4'd2, 20'h00000);
    do_op("addc1", C_ADDC, 4'd1, 4'd2, 1'b1, 4'd1, 20'h00000, 3'b101, 1'b1);
    idle_chk("addc1");

    // SWAP r3/r4: two writes, flags held
    do_op("swap", C_SWAP, 4'd3, 4'd4, 1'b1, 4'd3, 20'h0ABCD, 3'b101, 1'b1);
    @(negedge clk);
    check_eq("swap_wb2_we", 32'(rf_we), 32'd1);
    check_eq("swap_wb2_addr", 32'(rf_wr_addr), 32'd4);
    check_eq("swap_wb2_data", 32'(rf_wr_data), 32'h12345);
    check_eq("swap_wb2_rdy", 32'(op_if.op_ready), 32'd0);
    idle_chk("swap");
    // SWAP ra==rb keeps the register value
    do_op("swap_eq", C_SWAP, 4'd3, 4'd3, 1'b1, 4'd3, 20'h0ABCD, 3'b101, 1'b1);
    @(negedge clk);
    check_eq("swap_eq_wb2_we", 32'(rf_we), 32'd1);
    idle_chk("swap_eq");
    check_eq("swap_eq_r3", 32'(rf[3]), 32'h0ABCD);
    check_eq("swap_r4", 32'(rf[4]), 32'h12345);

    // Following ADDC sees carry_in=1: 0+0+1 -> 1, C cleared
    do_op("addc2", C_ADDC, 4'd2, 4'd2, 1'b1, 4'd2, 20'h00001, 3'b000, 1'b1);
    idle_chk("addc2");

    // GET 7>=7 -> Z=1 N=0, no write
    do_op("get", C_GET, 4'd9, 4'd10, 1'b0, 4'd0, 20'h0, 3'b100, 1'b0);
    idle_chk("get");
    // LT 2<9 -> N=1, Z held
    do_op("lt", C_LT, 4'd11, 4'd12, 1'b0, 4'd0, 20'h0, 3'b110, 1'b0);
    idle_chk("lt");

    // Illegal code: one-cycle pulse, no write, flags held
    accept("ill", 20'h00000, 4'd1, 4'd2);
    check_eq("ill_pulse", 32'(illegal), 32'd1);
    check_eq("ill_rdy", 32'(op_if.op_ready), 32'd1);
    check_eq("ill_busy", 32'(busy), 32'd0);
    check_eq("ill_we", 32'(rf_we), 32'd0);
    check_eq("ill_flags", 32'({flag_z, flag_n, flag_c}), 32'b110);
    @(negedge clk);
    check_eq("ill_end", 32'(illegal), 32'd0);
    check_eq("ill_we2", 32'(rf_we), 32'd0);

    // Reset during EXEC of SUB drops the write and clears flags
    accept("rsub", C_SUB, 4'd13, 4'd14);
    @(negedge clk);
    check_eq("rsub_ex_instr", 32'(alu_instr), 32'(C_SUB));
    rst = 1'b1;
    @(negedge clk);
    check_eq("rsub_we", 32'(rf_we), 32'd0);
    check_eq("rsub_flags", 32'({flag_z, flag_n, flag_c}), 32'd0);
    check_eq("rsub_rdy", 32'(op_if.op_ready), 32'd1);
    check_eq("rsub_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rsub_we_after", 32'(rf_we), 32'd0);
    check_eq("rsub_r13", 32'(rf[13]), 32'h00010);

    // Next op runs normally: 0x10-0x20 -> FFFF0, N=1, C held
    do_op("sub", C_SUB, 4'd13, 4'd14, 1'b1, 4'd13, 20'hFFFF0, 3'b010, 1'b0);
    idle_chk("sub");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage sequencer for the 20-bit ALU. It accepts one decoded ALU instruction at a time over a valid/ready handshake and reads both operands from the register file. It drives the combinational ALU, writes results back and maintains the Z/N/C status flags. It sits between the decode stage and the register file, owns the ALU's control input, and supplies the ALU's carry-in.

## Interface
- DATA_W, 20, datapath width; must match the ALU.
- REG_AW, 4, register-file address width (16 registers).
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  decode presents an instruction.
- op_ready  out  1  controller can accept; high only in IDLE.
- op_code  in  20  ALU instruction code.
- op_ra / op_rb  in  REG_AW  operand A / B register indices; ra is the destination.
- rf_rd_a_addr / rf_rd_b_addr  out  REG_AW  register-file read addresses.
- rf_rd_a_data / rf_rd_b_data  in  DATA_W  read data, valid one cycle after the address.
- rf_we  out  1  write strobe.
- rf_wr_addr  out  REG_AW  write address.
- rf_wr_data  out  DATA_W  write data.
- alu_instr  out  20  ALU control code.
- alu_a / alu_b  out  DATA_W  ALU operands.
- alu_carry_in  out  1  equals flag_c.
- alu_result  in  DATA_W  ALU result.
- alu_carry_out  in  1  ALU carry/borrow.
- flag_z / flag_n / flag_c  out  1  status flags.
- busy  out  1  high in every state except IDLE.
- illegal  out  1  one-cycle pulse when an unknown opcode is accepted.

## Operation
- Opcode classes, all 20-bit hex:
  - Logic: NOT 000A1, OR 000C9, AND 000B5, XOR 000DD.
  - Shift/rotate: SHFTR 000F1, SHFTL 00105, ROTR 00119, ROTL 0012D.
  - Swap: SWAP 00011.
  - Arithmetic: INC 00141, DEC 00155, ADD 00169, ADDC 0017D, SUB 00191, SUBC 001A5.
  - Compare: EQ 001B9, GT 001CD, LT 001E1, GET 001F5, LET 00209.
  - Any other code is illegal.
- FSM states: IDLE, READ, EXEC, WB, WB2.
  - IDLE: on op_valid&op_ready, latch op_code/ra/rb and drive the read addresses. A legal code goes to READ. An illegal code pulses illegal the next cycle, stays in IDLE, and makes no write and no flag change.
  - READ: latch rf_rd_a_data/rf_rd_b_data into A/B, then go to EXEC.
  - EXEC: alu_instr=op, alu_a=A, alu_b=B; register alu_result and alu_carry_out, then go to WB.
  - WB: writeback and flag update per class; go to IDLE, except SWAP goes to WB2.
  - WB2 (SWAP only): write A to rb, then go to IDLE.
- Writeback and flag update per class:
  - Logic, shift and arithmetic: write the result to ra. Z=(result==0), N=result[19].
  - C is updated only by ADDC and SUBC, taking alu_carry_out. All other ops hold C.
  - INC/DEC ignore B.
  - Shift and rotate amounts are B as passed to the ALU; the controller does not clamp them.
- SWAP: WB writes B to ra, WB2 writes A to rb. Flags are unchanged. With ra==rb the register keeps its original value.
- Compare ops make no register write (rf_we=0 in WB). Compares are unsigned, on the latched A and B:
  - EQ: Z=(A==B); N held.
  - GT: N=(A>B); Z held.
  - LT: N=(A<B); Z held.
  - GET: Z=(A>=B), N=!(A>=B).
  - LET: Z=N=(A<=B).
  - C is held for all compares.
- alu_instr, alu_a and alu_b hold their last values outside EXEC; only EXEC values are meaningful.

## Timing
- Reset values: state IDLE; op_ready=1; busy=0; illegal=0; rf_we=0; rf_wr_addr=0; rf_wr_data=0; alu_instr=0; alu_a=0; alu_b=0; flag_z=flag_n=flag_c=0.
- Accept-to-write latency:
  - 3 cycles: accept edge, READ, EXEC, then write in WB.
  - SWAP makes its second write 4 cycles after accept.
- Throughput: 4 cycles per op (5 for SWAP). op_ready deasserts the cycle after acceptance and reasserts on return to IDLE.
- Back-to-back: a new op may be accepted on the same edge that leaves WB/WB2 only if op_ready is high that cycle. It is not, so the minimum spacing is the latency plus one IDLE cycle.
- rf_we is high for exactly one cycle per write and is registered.
- Reset asserted in any state:
  - Takes effect on the next edge and returns the FSM to IDLE.
  - Suppresses any pending write (rf_we=0 that cycle) and clears the flags.
  - Discards the in-flight op.
- op_valid held high with op_ready=0 has no effect, and the inputs are not sampled.
- alu_carry_in is registered flag_c, so ADDC sees C as it was before the current op.

## Test plan
- Reset, then ADD: r1=0x00005, r2=0x00003, ra=1, rb=2 -> rf_we pulses 3 cycles after accept with addr 1, data 0x00008; Z=0, N=0, C=0 unchanged.
- ADDC with C=1: r1=0xFFFFF, r2=0x00000, and alu_carry_out=1 from the ALU model -> r1=0x00000, Z=1, C=1. A following ADDC sees alu_carry_in=1.
- SWAP r3=0x12345, r4=0x0ABCD -> WB writes addr 3 data 0x0ABCD; the next cycle writes addr 4 data 0x12345. Flags unchanged. Repeating with ra==rb leaves the register unchanged.
- Compares: GET with A=7, B=7 -> Z=1, N=0, no rf_we. LT with A=2, B=9 -> N=1, Z held.
- Illegal op_code 0x00000 -> illegal pulses one cycle, no rf_we, flags unchanged, op_ready high again the next cycle.
- Assert rst during EXEC of SUB -> no write occurs, flags=0, op_ready=1 after the reset edge, and the next op executes normally.
